// File: rtl/counter_pkg.sv
// Shared defaults and count type for the counter block.
package counter_pkg;

  localparam int unsigned COUNTER_DEFAULT_WIDTH = 8;
  localparam int unsigned COUNTER_DEFAULT_STEP  = 1;

  typedef logic [COUNTER_DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/counter.sv
// Free-running up-counter with async active-high reset and wrap at MAX_VALUE.
// Define COUNTER_SATURATE_EN to stop at MAX_VALUE instead of wrapping.
module counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = COUNTER_DEFAULT_WIDTH,
  parameter longint unsigned STEP      = 64'(COUNTER_DEFAULT_STEP),
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1
) (
  output logic [WIDTH-1:0] value,
  input  logic             clk,
  input  logic             reset
);

  localparam int unsigned     SW   = WIDTH + 1;
  localparam longint unsigned FULL = (64'd1 << WIDTH) - 64'd1;

  // Elaboration-time parameter legality checks
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "counter: WIDTH=%0d outside 2..32", WIDTH);
  end
  if (STEP < 1 || STEP > FULL) begin : g_bad_step
    $fatal(1, "counter: STEP=%0d outside 1..2**WIDTH-1", STEP);
  end
  if (MAX_VALUE < STEP || MAX_VALUE > FULL) begin : g_bad_max
    $fatal(1, "counter: MAX_VALUE=%0d outside STEP..2**WIDTH-1", MAX_VALUE);
  end

  logic [SW-1:0]    sum;
  logic [WIDTH-1:0] value_next;

  // value + STEP <= 2*MAX_VALUE, so a single subtraction completes the wrap
  always_comb begin
    sum        = SW'(value) + SW'(STEP);
    value_next = WIDTH'(sum);
    if (sum > SW'(MAX_VALUE)) begin
`ifdef COUNTER_SATURATE_EN
      value_next = WIDTH'(MAX_VALUE);
`else
      value_next = WIDTH'(sum - SW'(MAX_VALUE + 64'd1));
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value <= '0;
    else       value <= value_next;
  end

endmodule

// File: tb/tb_counter.sv
// Directed self-checking bench for counter: reset timing, wrap, step/max, saturate.
module tb_counter;

  logic       clk;
  logic       reset;
  logic       rs;
  logic [7:0] v8;
  logic [3:0] vp;
  logic [3:0] vs;

  int unsigned n_chk;
  int unsigned n_fail;

  counter u_dut (.value(v8), .clk(clk), .reset(reset));
  counter #(.WIDTH(4), .STEP(3), .MAX_VALUE(9)) u_p (.value(vp), .clk(clk), .reset(rs));
  counter #(.WIDTH(4)) u_s (.value(vs), .clk(clk), .reset(rs));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  e8;
    logic [3:0]  ptab [8];
    logic [3:0]  es;
    n_chk  = 0;
    n_fail = 0;
    ptab   = '{4'd3, 4'd6, 4'd9, 4'd2, 4'd5, 4'd8, 4'd1, 4'd4};
    reset  = 1'b0;
    rs     = 1'b1;

    // initial reset: high 17 ns, low 28 ns
    #17 reset = 1'b1;
    #1  chk("async_reset_initial", 32'(v8), 32'd0);
    #10 reset = 1'b0;
    #8  chk("first_inc_35", 32'(v8), 32'd1);
    #10 chk("inc_45", 32'(v8), 32'd2);
    #10 chk("inc_55", 32'(v8), 32'd3);

    // mid-count reset: high 57 ns, low 68 ns
    #1  reset = 1'b1;
    #1  chk("async_reset_midcount", 32'(v8), 32'd0);
    #10 reset = 1'b0;
    #8  chk("restart_75", 32'(v8), 32'd1);
    repeat (9) @(posedge clk);
    #1  chk("reach10_165", 32'(v8), 32'd10);

    // full wrap: 255 -> 0 -> 1
    e8 = 8'd10;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      e8 = e8 + 8'd1;
      chk("wrap_seq", 32'(v8), 32'(e8));
    end

    // reset held across three edges
    @(negedge clk) reset = 1'b1;
    #1 chk("held_reset_assert", 32'(v8), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("held_reset_edge", 32'(v8), 32'd0);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 chk("held_reset_first_inc", 32'(v8), 32'd1);

    // parameterised wrap and saturation/wrap of 4-bit instances
    chk("p_reset", 32'(vp), 32'd0);
    chk("s_reset", 32'(vs), 32'd0);
    @(negedge clk) rs = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk);
      #1;
      if (i <= 8) chk("p_seq", 32'(vp), 32'(ptab[i-1]));
`ifdef COUNTER_SATURATE_EN
      es = (i <= 15) ? 4'(i) : 4'd15;
`else
      es = 4'(i);
`endif
      chk("s_seq", 32'(vs), 32'(es));
    end
    @(negedge clk) rs = 1'b1;
    #1 chk("s_reset_after", 32'(vs), 32'd0);
    chk("p_reset_after", 32'(vp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/counter.md
# counter

Free-running synchronous up-counter with asynchronous active-high reset. Increments its output once per rising clock edge and wraps at a configurable terminal value. Used as a basic timebase/event counter and as the reference block for the simulation flow, including waveform dump and console monitoring.

## Interface
Parameters:
- WIDTH, 8: counter and output width in bits; legal range 2..32.
- STEP, 1: increment per clock; legal range 1..2**WIDTH-1.
- MAX_VALUE, 2**WIDTH-1: terminal count; legal range STEP..2**WIDTH-1.

Ports. Positional order in the module header is value, clk, reset.
- clk, input, 1: sole clock; rising-edge active.
- reset, input, 1: asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- value, output, WIDTH: current count, driven directly from the count register.

## Operation
- reset=1: value forced to 0 immediately, without waiting for a clock edge, and held at 0 for as long as reset stays high.
- reset=0, on each rising clk edge: value_next = value + STEP, computed in WIDTH+1 bits.
- Wrap rule: if value + STEP > MAX_VALUE, value_next = value + STEP - (MAX_VALUE + 1), reduced modulo MAX_VALUE+1. With defaults, 255 -> 0.
- No enable, load or direction control; the counter always counts when out of reset.
- Before the first reset assertion, value is undefined (X in simulation). There is no power-on initialiser.
- value is glitch-free: a register output with no combinational path to the port.

## Timing
- Latency: one clock edge from reset deassertion to the first increment.
  - reset falling between edges: the next rising edge gives value=STEP.
  - reset falling coincident with an edge: that edge is ignored and the following edge increments.
- Reset assertion mid-count: value goes to 0 asynchronously, regardless of clk phase.
- Repeated reset pulses restart the count from 0 each time; no history is kept.
- Reset is asserted asynchronously and must be released synchronously to clk by the system. The block has no internal synchroniser.

## Configuration
- COUNTER_SATURATE_EN defined:
  - the counter stops at MAX_VALUE instead of wrapping;
  - value holds at MAX_VALUE until reset.
  - If value + STEP > MAX_VALUE, value_next = MAX_VALUE.
- COUNTER_SATURATE_EN undefined (default): wrap behaviour as in Operation.
- The port list is identical in both builds.

## Structure
- Shared package counter_pkg:
  - COUNTER_DEFAULT_WIDTH = 8;
  - COUNTER_DEFAULT_STEP = 1;
  - typedef count_t as logic [COUNTER_DEFAULT_WIDTH-1:0].
- Single module with one always block (async reset, posedge clk) and one combinational next-value expression.
- No sub-module is warranted.
- Parameter legality checks (WIDTH, STEP, MAX_VALUE ranges) are done at elaboration with fatal errors.

## Test plan
Clock period 10 ns, first rising edge at 5 ns, defaults unless stated.
- Initial reset: reset high at 17 ns, low at 28 ns -> value=0 from 17 ns (asynchronous); 1 at 35 ns, 2 at 45 ns, 3 at 55 ns.
- Mid-count reset: reset high at 57 ns, low at 68 ns -> value=0 at 57 ns without a clock edge; 1 at 75 ns, reaching 10 at 165 ns.
- Wrap: release reset and run 256 edges -> value 255 is followed by 0, then 1.
- Parameterised wrap: WIDTH=4, MAX_VALUE=9, STEP=3 -> sequence 0,3,6,9,2,5,8,1.
- Saturation: build with COUNTER_SATURATE_EN, WIDTH=4 -> value reaches 15 and stays 15 for 10 further edges; reset returns it to 0.
- Reset held across edges: reset high for 3 rising edges -> value stays 0 throughout; first increment occurs on the first edge after release.
